// File: rtl/flash_controller.sv
// AMD-style byte-mode NOR flash bus engine: one command per Start edge, each expanded
// into timed write/read bus cycles, with DQ7 data polling for program/erase completion.
module flash_controller #(
    parameter int          ADDR_W   = 20,
    parameter int          T_RD     = 4,
    parameter int          T_WP     = 4,
    parameter logic [25:0] POLL_MAX = 26'h3FFFFFF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [ADDR_W-1:0] iADDR,
    input  logic [7:0]        iDATA,
    input  logic [2:0]        iCMD,
    input  logic              iStart,
    output logic [7:0]        oDATA,
    output logic              oReady,
    output logic [ADDR_W-1:0] FL_ADDR,
    inout  wire  [7:0]        FL_DQ,
    output logic              FL_CE_N,
    output logic              FL_OE_N,
    output logic              FL_WE_N,
    output logic              FL_RST_N
);
    localparam logic [2:0] CMD_READ = 3'd0, CMD_PROG = 3'd1, CMD_SERASE = 3'd2,
                           CMD_CERASE = 3'd3, CMD_RDID = 3'd4, CMD_RESET = 3'd5;
    localparam logic [ADDR_W-1:0] A_AAA = ADDR_W'(12'hAAA);
    localparam logic [ADDR_W-1:0] A_555 = ADDR_W'(12'h555);
    localparam logic [ADDR_W-1:0] A_000 = '0;

    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC, R_REC, NEXT, POLL_CHK, ABORT, DONE
    } state_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_POLL, OP_END} opKind_t;
    typedef struct packed {
        opKind_t           kind;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } busOp_t;

    function automatic busOp_t mkOp(input opKind_t k, input logic [ADDR_W-1:0] a,
                                    input logic [7:0] d);
        busOp_t o;
        o.kind = k;
        o.addr = a;
        o.data = d;
        return o;
    endfunction

    // Bus cycle number 'step' of command 'cmd'; OP_END once the sequence is exhausted.
    function automatic busOp_t seqOp(input logic [2:0] cmd, input logic [2:0] step,
                                     input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        busOp_t op;
        op = mkOp(OP_END, A_000, 8'h00);
        if ((cmd == CMD_PROG || cmd == CMD_SERASE || cmd == CMD_CERASE || cmd == CMD_RDID)
            && step < 3'd2) begin
            op = (step == 3'd0) ? mkOp(OP_WR, A_AAA, 8'hAA) : mkOp(OP_WR, A_555, 8'h55);
        end else begin
            case (cmd)
                CMD_READ: if (step == 3'd0) op = mkOp(OP_RD, addr, 8'h00);
                CMD_PROG: case (step)
                    3'd2:    op = mkOp(OP_WR, A_AAA, 8'hA0);
                    3'd3:    op = mkOp(OP_WR, addr, data);
                    3'd4:    op = mkOp(OP_POLL, addr, 8'h00);
                    default: ;
                endcase
                CMD_SERASE, CMD_CERASE: case (step)
                    3'd2:    op = mkOp(OP_WR, A_AAA, 8'h80);
                    3'd3:    op = mkOp(OP_WR, A_AAA, 8'hAA);
                    3'd4:    op = mkOp(OP_WR, A_555, 8'h55);
                    3'd5:    op = (cmd == CMD_SERASE) ? mkOp(OP_WR, addr, 8'h30)
                                                      : mkOp(OP_WR, A_AAA, 8'h10);
                    3'd6:    op = mkOp(OP_POLL, addr, 8'h00);
                    default: ;
                endcase
                CMD_RDID: case (step)
                    3'd2:    op = mkOp(OP_WR, A_AAA, 8'h90);
                    3'd3:    op = mkOp(OP_RD, addr, 8'h00);
                    3'd4:    op = mkOp(OP_WR, A_000, 8'hF0);
                    default: ;
                endcase
                CMD_RESET: if (step == 3'd0) op = mkOp(OP_WR, A_000, 8'hF0);
                default: ;
            endcase
        end
        return op;
    endfunction

    state_t            state;
    logic [2:0]        cmdReg, stepReg, lnStep, lnCmd;
    logic [ADDR_W-1:0] addrReg, lnAddr;
    logic [7:0]        dataReg, lnData, dqOut, resultReg;
    logic [7:0]        timer;
    logic [25:0]       pollCnt;
    logic              startPrev, dqOe, pollRd, pollBit, abortReg, accept, launch;
    busOp_t            lnOp;

    assign FL_DQ    = dqOe ? dqOut : 8'hzz;
    assign FL_RST_N = ~iRST;
    assign accept   = iStart && !startPrev && (state == IDLE);

    // Selects the bus cycle to launch: step 0 of the new command on accept, else the next step.
    always_comb begin
        launch = 1'b0;
        lnStep = stepReg + 3'd1;
        lnCmd  = cmdReg;
        lnAddr = addrReg;
        lnData = dataReg;
        case (state)
            IDLE: if (accept) begin
                launch = 1'b1;
                lnStep = 3'd0;
                lnCmd  = iCMD;
                lnAddr = iADDR;
                lnData = iDATA;
            end
            NEXT:    launch = 1'b1;
            R_REC:   launch = !pollRd;
            default: ;
        endcase
        lnOp = seqOp(lnCmd, lnStep, lnAddr, lnData);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;   startPrev <= 1'b1; cmdReg <= '0;   stepReg <= '0;
            addrReg <= '0;   dataReg <= '0;     dqOut <= '0;    dqOe <= 1'b0;
            timer <= '0;     pollCnt <= '0;     pollRd <= 1'b0; pollBit <= 1'b0;
            abortReg <= 1'b0; resultReg <= '0;  oDATA <= '0;    oReady <= 1'b0;
            FL_ADDR <= '0;   FL_CE_N <= 1'b1;   FL_OE_N <= 1'b1; FL_WE_N <= 1'b1;
        end else begin
            startPrev <= iStart;
            case (state)
                IDLE: oReady <= 1'b0;
                W_SETUP: begin
                    FL_WE_N <= 1'b0;
                    timer   <= 8'(T_WP - 1);
                    state   <= W_PULSE;
                end
                W_PULSE: if (timer == 8'd0) begin
                    FL_WE_N <= 1'b1;
                    state   <= W_HOLD;
                end else timer <= timer - 8'd1;
                W_HOLD: begin
                    FL_CE_N <= 1'b1;
                    dqOe    <= 1'b0;
                    state   <= abortReg ? DONE : NEXT;
                    if (abortReg) resultReg <= 8'hFF;
                end
                R_ACC: if (timer == 8'd0) begin
                    pollBit <= FL_DQ[7];
                    if (!pollRd) resultReg <= FL_DQ;
                    FL_CE_N <= 1'b1;
                    FL_OE_N <= 1'b1;
                    state   <= R_REC;
                end else timer <= timer - 8'd1;
                R_REC: if (pollRd) state <= POLL_CHK;
                POLL_CHK: begin
                    if (pollBit == ((cmdReg == CMD_PROG) ? dataReg[7] : 1'b1)) begin
                        state <= DONE;
                    end else begin
                        pollCnt <= pollCnt + 26'd1;
                        if (pollCnt == POLL_MAX - 26'd1) begin
                            state <= ABORT;
                        end else begin
                            FL_CE_N <= 1'b0;
                            FL_OE_N <= 1'b0;
                            timer   <= 8'(T_RD - 1);
                            state   <= R_ACC;
                        end
                    end
                end
                ABORT: begin
                    abortReg <= 1'b1;
                    FL_ADDR  <= A_000;
                    dqOut    <= 8'hF0;
                    dqOe     <= 1'b1;
                    FL_CE_N  <= 1'b0;
                    state    <= W_SETUP;
                end
                DONE: begin
                    oDATA  <= resultReg;
                    oReady <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (launch) begin
                stepReg <= lnStep;
                case (lnOp.kind)
                    OP_WR: begin
                        FL_ADDR <= lnOp.addr;
                        dqOut   <= lnOp.data;
                        dqOe    <= 1'b1;
                        FL_CE_N <= 1'b0;
                        state   <= W_SETUP;
                    end
                    OP_RD, OP_POLL: begin
                        FL_ADDR <= lnOp.addr;
                        FL_CE_N <= 1'b0;
                        FL_OE_N <= 1'b0;
                        pollRd  <= (lnOp.kind == OP_POLL);
                        timer   <= 8'(T_RD - 1);
                        state   <= R_ACC;
                    end
                    default: state <= DONE;
                endcase
            end

            if (accept) begin
                cmdReg    <= iCMD;
                addrReg   <= iADDR;
                dataReg   <= iDATA;
                pollCnt   <= '0;
                abortReg  <= 1'b0;
                resultReg <= 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_flash_controller.sv
// Self-checking bench: a bus monitor records every strobe cycle, and a transaction-level
// reference model predicts the bus cycle list, oDATA and latency for each command.
module tb_flash_controller;
    localparam int          T_RD     = 4;
    localparam int          T_WP     = 4;
    localparam logic [25:0] POLL_MAX = 26'd8;
    localparam int          PMAX     = 8;

    typedef struct packed {
        logic        isWr;
        logic [19:0] addr;
        logic [7:0]  data;
        logic [7:0]  len;
    } txn_t;

    logic        iCLK, iRST, iStart;
    logic [19:0] iADDR;
    logic [7:0]  iDATA;
    logic [2:0]  iCMD;
    logic [7:0]  oDATA;
    logic        oReady;
    logic [19:0] FL_ADDR;
    wire  [7:0]  FL_DQ;
    logic        FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N;

    int          checks = 0, failures = 0;
    int          cycle = 0, readCount = 0, busyReads = 0, readyCnt = 0;
    int          weLen = 0, oeLen = 0, overlapCnt = 0, dqViol = 0;
    logic        prevWe = 1'b1, prevOe = 1'b1;
    logic [19:0] rdAddr = '0;
    logic [7:0]  busyVal = 8'h00, doneVal = 8'h00;
    wire  [7:0]  flashOut = (readCount < busyReads) ? busyVal : doneVal;
    txn_t        obsQ[$];

    assign FL_DQ = (!FL_OE_N && !FL_CE_N) ? flashOut : 8'hzz;

    flash_controller #(.ADDR_W(20), .T_RD(T_RD), .T_WP(T_WP), .POLL_MAX(POLL_MAX)) dut (
        .iCLK(iCLK), .iRST(iRST), .iADDR(iADDR), .iDATA(iDATA), .iCMD(iCMD),
        .iStart(iStart), .oDATA(oDATA), .oReady(oReady), .FL_ADDR(FL_ADDR),
        .FL_DQ(FL_DQ), .FL_CE_N(FL_CE_N), .FL_OE_N(FL_OE_N), .FL_WE_N(FL_WE_N),
        .FL_RST_N(FL_RST_N)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cycle++;

    function automatic txn_t mkTxn(input logic w, input logic [19:0] a, input logic [7:0] d,
                                   input int l);
        txn_t t;
        t.isWr = w;
        t.addr = a;
        t.data = d;
        t.len  = 8'(l);
        return t;
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bus monitor: one record per completed WE_N or OE_N low pulse.
    always @(negedge iCLK) begin
        if (iRST) begin
            weLen = 0;
            oeLen = 0;
        end else begin
            if (!FL_OE_N && !FL_WE_N) overlapCnt++;
            if (FL_CE_N && FL_DQ !== 8'hzz) dqViol++;
            if (!FL_WE_N) weLen++;
            else if (!prevWe) begin
                obsQ.push_back(mkTxn(1'b1, FL_ADDR, FL_DQ, weLen));
                weLen = 0;
            end
            if (!FL_OE_N) begin
                if (prevOe) rdAddr = FL_ADDR;
                oeLen++;
            end else if (!prevOe) begin
                obsQ.push_back(mkTxn(1'b0, rdAddr, 8'h00, oeLen));
                oeLen = 0;
                readCount++;
            end
            if (oReady) readyCnt++;
        end
        prevWe = FL_WE_N;
        prevOe = FL_OE_N;
    end

    task automatic runCmd(input logic [2:0] cmd, input logic [19:0] addr, input logic [7:0] data,
                          input int busy, input logic [7:0] bVal, input logic [7:0] dVal);
        txn_t       expQ[$];
        logic [7:0] expOut;
        int         c0, lat, nPoll;
        bit         seen;
        expOut = 8'h00;
        case (cmd)
            3'd0: begin
                expQ.push_back(mkTxn(1'b0, addr, 8'h00, T_RD));
                expOut = dVal;
            end
            3'd1: begin
                expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'hAA, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'h555, 8'h55, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'hA0, T_WP));
                expQ.push_back(mkTxn(1'b1, addr, data, T_WP));
            end
            3'd2, 3'd3: begin
                expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'hAA, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'h555, 8'h55, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'h80, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'hAA, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'h555, 8'h55, T_WP));
                if (cmd == 3'd2) expQ.push_back(mkTxn(1'b1, addr, 8'h30, T_WP));
                else             expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'h10, T_WP));
            end
            3'd4: begin
                expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'hAA, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'h555, 8'h55, T_WP));
                expQ.push_back(mkTxn(1'b1, 20'hAAA, 8'h90, T_WP));
                expQ.push_back(mkTxn(1'b0, addr, 8'h00, T_RD));
                expQ.push_back(mkTxn(1'b1, 20'h000, 8'hF0, T_WP));
                expOut = dVal;
            end
            3'd5: expQ.push_back(mkTxn(1'b1, 20'h000, 8'hF0, T_WP));
            default: ;
        endcase
        if (cmd >= 3'd1 && cmd <= 3'd3) begin
            nPoll = (busy >= PMAX) ? PMAX : busy + 1;
            for (int i = 0; i < nPoll; i++) expQ.push_back(mkTxn(1'b0, addr, 8'h00, T_RD));
            if (busy >= PMAX) begin
                expQ.push_back(mkTxn(1'b1, 20'h000, 8'hF0, T_WP));
                expOut = 8'hFF;
            end
        end

        busyReads = busy;
        busyVal   = bVal;
        doneVal   = dVal;
        @(negedge iCLK);
        obsQ.delete();
        readCount = 0;
        readyCnt  = 0;
        iCMD = cmd; iADDR = addr; iDATA = data; iStart = 1'b1;
        c0 = cycle;
        @(negedge iCLK);
        iStart = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (oReady) seen = 1'b1;
            else @(negedge iCLK);
        end
        lat = cycle - c0 - 1;
        checkEq("ready_seen", 64'(seen), 64'd1);
        checkEq("odata", 64'(oDATA), 64'(expOut));
        if (cmd == 3'd0) checkEq("read_latency", 64'(lat), 64'(T_RD + 2));
        if (cmd >= 3'd6) checkEq("nop_latency", 64'(lat), 64'd1);
        @(negedge iCLK);
        checkEq("ready_width", 64'(oReady), 64'd0);
        checkEq("ready_count", 64'(readyCnt), 64'd1);
        checkEq("txn_count", 64'(obsQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
            checkEq($sformatf("txn%0d", i), 64'(obsQ[i]), 64'(expQ[i]));
        $display("cmd=%0d addr=%h data=%h busy=%0d oDATA=%h lat=%0d txns=%0d",
                 cmd, addr, data, busy, oDATA, lat, obsQ.size());
    endtask

    initial begin
        logic [2:0]  rc;
        logic [19:0] ra;
        logic [7:0]  rd, r7;
        logic        eb;
        int          rb;

        iRST = 1'b1; iStart = 1'b1; iCMD = 3'd0; iADDR = '0; iDATA = '0;
        repeat (3) @(negedge iCLK);
        checkEq("rst_strobes", 64'({FL_CE_N, FL_OE_N, FL_WE_N}), 64'h7);
        checkEq("rst_flrst", 64'(FL_RST_N), 64'd0);
        checkEq("rst_out", 64'({oReady, oDATA}), 64'd0);
        checkEq("rst_dq_z", 64'(FL_DQ === 8'hzz), 64'd1);
        iRST = 1'b0;
        obsQ.delete();
        readyCnt = 0;
        repeat (10) @(negedge iCLK);
        checkEq("held_start_no_op", 64'({obsQ.size(), readyCnt}), 64'd0);
        checkEq("flrst_released", 64'(FL_RST_N), 64'd1);
        iStart = 1'b0;
        @(negedge iCLK);

        runCmd(3'd0, 20'h12345, 8'h00, 0, 8'h00, 8'hA5);
        runCmd(3'd1, 20'h00010, 8'h3C, 3, 8'hBC, 8'h3C);
        runCmd(3'd2, 20'h20000, 8'h00, 100, 8'h00, 8'hFF);

        // Reset in the middle of a PROGRAM write pulse.
        @(negedge iCLK);
        iCMD = 3'd1; iADDR = 20'h00777; iDATA = 8'h11; iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        for (int i = 0; i < 50 && FL_WE_N; i++) @(negedge iCLK);
        checkEq("we_pulse_seen", 64'(FL_WE_N), 64'd0);
        #2 iRST = 1'b1;
        #1;
        checkEq("async_rst_strobes", 64'({FL_CE_N, FL_WE_N, FL_OE_N}), 64'h7);
        checkEq("async_rst_dq_z", 64'(FL_DQ === 8'hzz), 64'd1);
        checkEq("async_rst_out", 64'({oReady, oDATA}), 64'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        runCmd(3'd0, 20'hABCDE, 8'h00, 0, 8'h00, 8'h69);

        // Second rising edge while busy, then Start held through completion.
        busyReads = 0; doneVal = 8'h5A;
        @(negedge iCLK);
        obsQ.delete(); readCount = 0; readyCnt = 0;
        iCMD = 3'd0; iADDR = 20'h00042; iStart = 1'b1;
        @(negedge iCLK); iStart = 1'b0;
        @(negedge iCLK); @(negedge iCLK); iStart = 1'b1;
        repeat (30) @(negedge iCLK);
        checkEq("hs_ready_count", 64'(readyCnt), 64'd1);
        checkEq("hs_txn_count", 64'(obsQ.size()), 64'd1);
        checkEq("hs_odata", 64'(oDATA), 64'h5A);
        $display("handshake: pulses=%0d txns=%0d oDATA=%h", readyCnt, obsQ.size(), oDATA);
        iStart = 1'b0;
        @(negedge iCLK);

        for (int n = 0; n < 25; n++) begin
            rc = 3'($urandom_range(0, 7));
            ra = 20'($urandom);
            rd = 8'($urandom);
            r7 = 8'($urandom);
            rb = 0;
            eb = (rc == 3'd1) ? rd[7] : 1'b1;
            if (rc >= 3'd1 && rc <= 3'd3) rb = $urandom_range(0, 9);
            if (rc == 3'd1)
                runCmd(rc, ra, rd, rb, {~eb, r7[6:0]}, rd);
            else if (rc == 3'd2 || rc == 3'd3)
                runCmd(rc, ra, rd, rb, {~eb, r7[6:0]}, {eb, r7[6:0]});
            else
                runCmd(rc, ra, rd, 0, 8'h00, r7);
        end

        checkEq("oe_we_overlap", 64'(overlapCnt), 64'd0);
        checkEq("dq_driven_idle", 64'(dqViol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
